// File: rtl/mp_pkg.sv
// Motion-prediction shared constants and types.
// Imported by the pixel fetch responder and the motion predictor.
package mp_pkg;

   localparam int          WIDTH     = 640;
   localparam int          HEIGHT    = 480;
   localparam logic [10:0] NOT_FOUND = 11'd2023;

   // pixel word {8'h00, r, g, b}
   localparam int PIX_R_LSB = 16;
   localparam int PIX_G_LSB = 8;
   localparam int PIX_B_LSB = 0;

   // stats word {16'h0000, mean, var}
   localparam int ST_MEAN_LSB = 8;
   localparam int ST_VAR_LSB  = 0;

   // S_OOR delays an out-of-range reply by one cycle.
   // This gives a fixed two-cycle out-of-range latency.
   typedef enum logic [2:0] {
      S_IDLE,
      S_OOR,
      S_REQ_PIX,
      S_WAIT_PIX,
      S_REQ_BG,
      S_WAIT_BG,
      S_RESP
   } fetch_state_t;

endpackage

// File: rtl/pix_addr_gen.sv
// Frame word-address generator: base + y*640 + x, shift-add only.
// Also flags coordinates outside the frame.
module pix_addr_gen #(
   parameter int WIDTH  = mp_pkg::WIDTH,
   parameter int HEIGHT = mp_pkg::HEIGHT,
   parameter int ADDR_W = 32
) (
   input  logic [10:0]       x,
   input  logic [10:0]       y,
   input  logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] addr,
   output logic              oor
);

   localparam logic [10:0] W11 = 11'(WIDTH);
   localparam logic [10:0] H11 = 11'(HEIGHT);

   logic [20:0] yw;
   logic [20:0] offset;

   assign yw     = {10'd0, y};
   assign offset = (yw << 9) + (yw << 7) + {10'd0, x};
   assign addr   = base + {{(ADDR_W-21){1'b0}}, offset};
   assign oor    = (x >= W11) || (y >= H11);

endmodule

// File: rtl/pixel_fetch_responder.sv
// Pixel request responder: reads live RGB then background stats
// for one coordinate and returns them with a one-cycle strobe.
module pixel_fetch_responder #(
   parameter int                WIDTH    = 640,
   parameter int                HEIGHT   = 480,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] PIX_BASE = '0,
   parameter logic [ADDR_W-1:0] BG_BASE  = ADDR_W'(32'h0004_B000)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_coord_valid,
   input  logic [10:0]       i_x,
   input  logic [10:0]       i_y,
   output logic              o_busy,
   output logic              o_valid,
   output logic [7:0]        o_r,
   output logic [7:0]        o_g,
   output logic [7:0]        o_b,
   output logic [7:0]        o_pix_x,
   output logic [7:0]        o_pix_x2,
   output logic              o_oor,
   output logic              o_drop,
   output logic              o_read,
   output logic [ADDR_W-1:0] o_address,
   input  logic              i_waitrequest,
   input  logic [31:0]       i_readdata,
   input  logic              i_readdatavalid
);

   import mp_pkg::*;

   fetch_state_t state;
   fetch_state_t next;

   logic [10:0]       x_q;
   logic [10:0]       y_q;
   logic [10:0]       ax;
   logic [10:0]       ay;
   logic [ADDR_W-1:0] abase;
   logic [ADDR_W-1:0] addr;
   logic              oor;
   logic              oor_q;
   logic              take;
   logic              load_addr;
   logic [7:0]        r_q;
   logic [7:0]        g_q;
   logic [7:0]        b_q;
   logic [7:0]        mean_q;
   logic [7:0]        var_q;
   logic              unused_hi;

   assign take  = (state == S_IDLE) && i_coord_valid;
   assign ax    = (state == S_IDLE) ? i_x : x_q;
   assign ay    = (state == S_IDLE) ? i_y : y_q;
   assign abase = (state == S_IDLE) ? PIX_BASE : BG_BASE;

   assign load_addr =
      ((state == S_IDLE)     && (next == S_REQ_PIX)) ||
      ((state == S_WAIT_PIX) && (next == S_REQ_BG));

   assign unused_hi = ^i_readdata[31:24];

   pix_addr_gen #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .ADDR_W (ADDR_W)
   ) u_addr (
      .x    (ax),
      .y    (ay),
      .base (abase),
      .addr (addr),
      .oor  (oor)
   );

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= next;
   end

   // next-state: pixel read, then stats read, then respond
   always_comb begin
      next = state;
      unique case (state)
         S_IDLE:
            if (i_coord_valid) next = oor ? S_OOR : S_REQ_PIX;
         S_OOR:
            next = S_RESP;
         S_REQ_PIX:
            if (!i_waitrequest) next = S_WAIT_PIX;
         S_WAIT_PIX:
            if (i_readdatavalid) next = S_REQ_BG;
         S_REQ_BG:
            if (!i_waitrequest) next = S_WAIT_BG;
         S_WAIT_BG:
            if (i_readdatavalid) next = S_RESP;
         S_RESP:
            next = S_IDLE;
         default:
            next = S_IDLE;
      endcase
   end

   // state-decoded requester outputs
   always_comb begin
      o_valid = (state == S_RESP);
      o_busy  = (state != S_IDLE);
      o_oor   = (state == S_RESP) && oor_q;
   end

   // registered memory command, held while the read is stalled
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_read    <= 1'b0;
         o_address <= PIX_BASE;
      end else begin
         o_read <= (next == S_REQ_PIX) || (next == S_REQ_BG);
         if (load_addr) o_address <= addr;
      end
   end

   // coordinate latch, read-data capture and sticky drop flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         x_q    <= '0;
         y_q    <= '0;
         oor_q  <= 1'b0;
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         mean_q <= '0;
         var_q  <= '0;
         o_drop <= 1'b0;
      end else begin
         if (take) begin
            x_q   <= i_x;
            y_q   <= i_y;
            oor_q <= oor;
            if (oor) begin
               r_q    <= '0;
               g_q    <= '0;
               b_q    <= '0;
               mean_q <= '0;
               var_q  <= 8'hFF;
            end
         end
         if ((state == S_WAIT_PIX) && i_readdatavalid) begin
            r_q <= i_readdata[PIX_R_LSB +: 8];
            g_q <= i_readdata[PIX_G_LSB +: 8];
            b_q <= i_readdata[PIX_B_LSB +: 8];
         end
         if ((state == S_WAIT_BG) && i_readdatavalid) begin
            mean_q <= i_readdata[ST_MEAN_LSB +: 8];
            var_q  <= i_readdata[ST_VAR_LSB +: 8];
         end
         if (i_coord_valid && (state != S_IDLE)) o_drop <= 1'b1;
      end
   end

   assign o_r      = r_q;
   assign o_g      = g_q;
   assign o_b      = b_q;
   assign o_pix_x  = mean_q;
   assign o_pix_x2 = var_q;

endmodule
